seq_match_fsm: RTL and testbench

Parametrised sequence-recognition FSM: watches a stream of SYM_W-bit input symbols and flags every occurrence of a DEPTH-symbol pattern. Supersedes the fixed two-input Mealy FSMs in the control library. Adds configurable symbol width and pattern length, a runtime-loadable pattern, an overlap/non-overlap mode, a Mealy/Moore output select, input stalls and a saturating match counter. Sits between input sampling logic and the control/status block that consumes match events.

---
 rtl/seq_match_fsm.sv | 78 +++++++
 tb/tb_seq_match_fsm.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_fsm.sv
// Sequence recogniser: flags every occurrence of a DEPTH-symbol pattern in a
// stream of SYM_W-bit symbols, with a runtime-loadable pattern and saturating hit count.
module seq_match_fsm #(
  parameter int                       SYM_W    = 2,
  parameter int                       DEPTH    = 4,
  parameter logic [DEPTH*SYM_W-1:0]   PAT_INIT = 8'h78,
  parameter bit                       OVERLAP  = 1'b1,
  parameter bit                       MEALY    = 1'b1,
  parameter int                       CNT_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [SYM_W-1:0]           in_sym,
  input  logic                       pat_we,
  input  logic [$clog2(DEPTH):0]     pat_idx,
  input  logic [SYM_W-1:0]           pat_sym,
  output logic                       match,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [DEPTH-1:0]           prog
);

  // Handshake: in_valid qualifies in_sym and there is no ready; a symbol is
  // consumed on any edge where in_valid=1 and neither clr nor pat_we is high.

  logic [SYM_W-1:0] pat_q [DEPTH];
  logic [SYM_W-1:0] pat_d [DEPTH];
  logic [DEPTH-1:0] prog_q, prog_d, nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mreg_q, mreg_d;
  logic             accept, wr_ok, hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) pat_q[k] <= PAT_INIT[k*SYM_W +: SYM_W];
      prog_q <= '0;
      cnt_q  <= '0;
      mreg_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      prog_q <= prog_d;
      cnt_q  <= cnt_d;
      mreg_q <= mreg_d;
    end
  end

  always_comb begin
    accept = in_valid & ~pat_we & ~clr;
    wr_ok  = pat_we && (int'(pat_idx) < DEPTH);

    // One bit per pattern prefix; several prefixes may be live at once.
    nxt    = '0;
    nxt[0] = (in_sym == pat_q[0]);
    for (int k = 1; k < DEPTH; k++) nxt[k] = prog_q[k-1] & (in_sym == pat_q[k]);
    hit = accept & nxt[DEPTH-1];

    prog_d = prog_q;
    if (clr || wr_ok)      prog_d = '0;
    else if (accept)       prog_d = (!OVERLAP && hit) ? '0 : nxt;

    // The pattern write still lands when clr is high.
    pat_d = pat_q;
    for (int k = 0; k < DEPTH; k++)
      if (wr_ok && int'(pat_idx) == k) pat_d[k] = pat_sym;

    cnt_d = cnt_q;
    if (clr)                      cnt_d = '0;
    else if (hit && cnt_q != '1)  cnt_d = cnt_q + 1'b1;

    mreg_d = hit;
  end

  assign match     = MEALY ? hit : mreg_q;
  assign match_cnt = cnt_q;
  assign prog      = prog_q;

endmodule

// File: tb/tb_seq_match_fsm.sv
// Bench for seq_match_fsm: two instances (overlap/Mealy/8-bit count and
// non-overlap/registered/2-bit count) share one stimulus stream and a prefix-history model.
module tb_seq_match_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr = 1'b0, in_valid = 1'b0, pat_we = 1'b0;
  logic [1:0] in_sym = 2'b00, pat_sym = 2'b00;
  logic [2:0] pat_idx = 3'd0;

  logic       a_match, b_match;
  logic [7:0] a_cnt;
  logic [1:0] b_cnt;
  logic [3:0] a_prog, b_prog;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_match_fsm #(.SYM_W(2), .DEPTH(4), .PAT_INIT(8'h78), .OVERLAP(1'b1), .MEALY(1'b1), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_sym(in_sym),
    .pat_we(pat_we), .pat_idx(pat_idx), .pat_sym(pat_sym),
    .match(a_match), .match_cnt(a_cnt), .prog(a_prog));

  seq_match_fsm #(.SYM_W(2), .DEPTH(4), .PAT_INIT(8'h78), .OVERLAP(1'b0), .MEALY(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .clr(clr), .in_valid(in_valid), .in_sym(in_sym),
    .pat_we(pat_we), .pat_idx(pat_idx), .pat_sym(pat_sym),
    .match(b_match), .match_cnt(b_cnt), .prog(b_prog));

  // Reference model: history of accepted symbols since the last clear point.
  logic [1:0] pat_m [4];
  logic [1:0] hist_a [$];
  logic [1:0] hist_b [$];
  int         cnt_a, cnt_b;
  logic       exp_q [$];

  function automatic logic [3:0] prog_of(input logic [1:0] h [$]);
    logic [3:0] r;
    logic       ok;
    int         n;
    r = '0;
    n = h.size();
    for (int k = 0; k < 4; k++) begin
      if (n >= k + 1) begin
        ok = 1'b1;
        for (int j = 0; j <= k; j++) if (h[n-1-k+j] != pat_m[j]) ok = 1'b0;
        r[k] = ok;
      end
    end
    return r;
  endfunction

  function automatic logic hit_with(input logic [1:0] h [$], input logic [1:0] s);
    logic [1:0] t [$];
    logic [3:0] p;
    t = h;
    t.push_back(s);
    p = prog_of(t);
    return p[3];
  endfunction

  initial forever begin
    logic acc, ha, hb;
    @(posedge clk or posedge reset);
    if (reset) begin
      hist_a.delete(); hist_b.delete();
      cnt_a = 0; cnt_b = 0;
      pat_m[0] = 2'b00; pat_m[1] = 2'b10; pat_m[2] = 2'b11; pat_m[3] = 2'b01;
      exp_q.delete();
      exp_q.push_back(1'b0);
    end else begin
      acc = in_valid && !pat_we && !clr;
      hb  = 1'b0;
      if (acc) begin
        ha = hit_with(hist_a, in_sym);
        hb = hit_with(hist_b, in_sym);
        hist_a.push_back(in_sym);
        hist_b.push_back(in_sym);
        if (hist_a.size() > 4) void'(hist_a.pop_front());
        if (hist_b.size() > 4) void'(hist_b.pop_front());
        if (ha && cnt_a < 255) cnt_a++;
        if (hb) begin
          if (cnt_b < 3) cnt_b++;
          hist_b.delete();
        end
      end
      if (clr || (pat_we && pat_idx < 3'd4)) begin
        hist_a.delete(); hist_b.delete();
      end
      if (clr) begin
        cnt_a = 0; cnt_b = 0;
      end
      if (pat_we && pat_idx < 3'd4) pat_m[pat_idx[1:0]] = pat_sym;
      exp_q.push_back(hb);
    end
  end

  // Scoreboard: every mid-cycle, compare both instances against the model.
  initial forever begin
    logic [3:0] pa, pb;
    logic       ea, eb;
    @(negedge clk);
    if (!reset) begin
      pa = prog_of(hist_a);
      pb = prog_of(hist_b);
      ea = in_valid && !pat_we && !clr && hit_with(hist_a, in_sym);
      checks += 6;
      if (a_prog !== pa) begin errors++; $display("FAIL sb_a_prog t=%0t got=%b exp=%b", $time, a_prog, pa); end
      if (b_prog !== pb) begin errors++; $display("FAIL sb_b_prog t=%0t got=%b exp=%b", $time, b_prog, pb); end
      if (a_cnt !== 8'(cnt_a)) begin errors++; $display("FAIL sb_a_cnt t=%0t got=%0d exp=%0d", $time, a_cnt, cnt_a); end
      if (b_cnt !== 2'(cnt_b)) begin errors++; $display("FAIL sb_b_cnt t=%0t got=%0d exp=%0d", $time, b_cnt, cnt_b); end
      if (a_match !== ea) begin errors++; $display("FAIL sb_a_match t=%0t got=%b exp=%b", $time, a_match, ea); end
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL sb_b_match t=%0t expected queue empty", $time);
      end else begin
        eb = exp_q.pop_front();
        if (b_match !== eb) begin errors++; $display("FAIL sb_b_match t=%0t got=%b exp=%b", $time, b_match, eb); end
      end
    end
  end

  // Driver: inputs applied just after a rising edge, held for the next one.
  task automatic drive(input logic c, input logic v, input logic [1:0] s,
                       input logic we, input logic [2:0] idx, input logic [1:0] ps);
    clr = c; in_valid = v; in_sym = s; pat_we = we; pat_idx = idx; pat_sym = ps;
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [1:0] s);
    drive(1'b0, 1'b1, s, 1'b0, 3'd0, 2'b00);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00);
  endtask

  task automatic write_pat(input logic [2:0] idx, input logic [1:0] ps);
    drive(1'b0, 1'b0, 2'b00, 1'b1, idx, ps);
  endtask

  task automatic send_default();
    send(2'b00); send(2'b10); send(2'b11); send(2'b01);
  endtask

  task automatic test_reset();
    checks += 4;
    if (a_prog !== 4'b0000) begin errors++; $display("FAIL reset_a_prog got=%b exp=0000", a_prog); end
    if (b_prog !== 4'b0000) begin errors++; $display("FAIL reset_b_prog got=%b exp=0000", b_prog); end
    if (a_cnt !== 8'd0 || b_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
    if (a_match !== 1'b0 || b_match !== 1'b0) begin errors++; $display("FAIL reset_match got=%b/%b exp=0/0", a_match, b_match); end
  endtask

  task automatic test_reset_mid();
    write_pat(3'd0, 2'b11);
    send(2'b11); send(2'b10); send(2'b11); send(2'b01);
    checks += 1;
    if (b_match !== 1'b1) begin errors++; $display("FAIL mid_pre_match got=%b exp=1", b_match); end
    clr = 1'b0; in_valid = 1'b0; pat_we = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks += 3;
    if (a_prog !== 4'b0 || b_prog !== 4'b0) begin errors++; $display("FAIL mid_prog got=%b/%b exp=0000/0000", a_prog, b_prog); end
    if (a_cnt !== 8'd0 || b_cnt !== 2'd0) begin errors++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
    if (b_match !== 1'b0) begin errors++; $display("FAIL mid_match got=%b exp=0", b_match); end
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    idle();
    checks += 1;
    if (b_match !== 1'b0) begin errors++; $display("FAIL mid_no_pulse got=%b exp=0", b_match); end
  endtask

  task automatic test_default();
    logic [3:0] exp_steps [4];
    logic [1:0] syms [4];
    exp_steps[0] = 4'b0001; exp_steps[1] = 4'b0010; exp_steps[2] = 4'b0100; exp_steps[3] = 4'b1000;
    syms[0] = 2'b00; syms[1] = 2'b10; syms[2] = 2'b11; syms[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      send(syms[i]);
      checks += 1;
      if (a_prog !== exp_steps[i]) begin errors++; $display("FAIL default_prog_%0d got=%b exp=%b", i, a_prog, exp_steps[i]); end
    end
    checks += 3;
    if (b_match !== 1'b1) begin errors++; $display("FAIL default_b_match got=%b exp=1", b_match); end
    if (b_prog !== 4'b0000) begin errors++; $display("FAIL default_b_prog got=%b exp=0000", b_prog); end
    if (a_cnt !== 8'd1 || b_cnt !== 2'd1) begin errors++; $display("FAIL default_cnt got=%0d/%0d exp=1/1", a_cnt, b_cnt); end
    idle();
    checks += 1;
    if (b_match !== 1'b0) begin errors++; $display("FAIL default_b_one_cycle got=%b exp=0", b_match); end
  endtask

  task automatic test_overlap();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00);
    for (int i = 0; i < 4; i++) write_pat(3'(i), 2'b00);
    for (int i = 0; i < 6; i++) send(2'b00);
    idle();
    checks += 3;
    if (a_cnt !== 8'd3) begin errors++; $display("FAIL overlap_a_cnt got=%0d exp=3", a_cnt); end
    if (b_cnt !== 2'd1) begin errors++; $display("FAIL nooverlap_b_cnt got=%0d exp=1", b_cnt); end
    if (b_prog !== 4'b0011) begin errors++; $display("FAIL nooverlap_b_prog got=%b exp=0011", b_prog); end
  endtask

  task automatic test_stall();
    logic [1:0] syms [4];
    syms[0] = 2'b00; syms[1] = 2'b10; syms[2] = 2'b11; syms[3] = 2'b01;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00);
    for (int i = 0; i < 4; i++) write_pat(3'(i), syms[i]);
    for (int i = 0; i < 4; i++) begin
      clr = 1'b0; pat_we = 1'b0; in_valid = 1'b0; in_sym = 2'b01;
      #1;
      checks += 1;
      if (a_match !== 1'b0) begin errors++; $display("FAIL stall_bubble_%0d got=%b exp=0", i, a_match); end
      @(posedge clk); #1;
      in_valid = 1'b1; in_sym = syms[i];
      #1;
      checks += 1;
      if (a_match !== (i == 3)) begin errors++; $display("FAIL stall_mealy_%0d got=%b exp=%b", i, a_match, (i == 3)); end
      @(posedge clk); #1;
    end
    idle();
    checks += 1;
    if (a_cnt !== 8'd1 || b_cnt !== 2'd1) begin errors++; $display("FAIL stall_cnt got=%0d/%0d exp=1/1", a_cnt, b_cnt); end
  endtask

  task automatic test_collisions();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00);
    send(2'b00); send(2'b10);
    drive(1'b0, 1'b1, 2'b11, 1'b1, 3'd0, 2'b00);
    checks += 1;
    if (a_prog !== 4'b0 || b_prog !== 4'b0) begin errors++; $display("FAIL coll_we_prog got=%b/%b exp=0000/0000", a_prog, b_prog); end
    send(2'b11); send(2'b01);
    checks += 1;
    if (a_cnt !== 8'd0) begin errors++; $display("FAIL coll_we_dropped got=%0d exp=0", a_cnt); end
    send(2'b00);
    write_pat(3'd4, 2'b11);
    checks += 1;
    if (a_prog !== 4'b0001) begin errors++; $display("FAIL coll_idx4_prog got=%b exp=0001", a_prog); end
    send(2'b10); send(2'b11); send(2'b01);
    checks += 1;
    if (a_cnt !== 8'd1) begin errors++; $display("FAIL coll_idx4_pat got=%0d exp=1", a_cnt); end
    send(2'b00); send(2'b10); send(2'b11);
    clr = 1'b1; in_valid = 1'b1; in_sym = 2'b01; pat_we = 1'b0;
    #1;
    checks += 1;
    if (a_match !== 1'b0) begin errors++; $display("FAIL coll_clr_mealy got=%b exp=0", a_match); end
    @(posedge clk); #1;
    checks += 2;
    if (a_cnt !== 8'd0 || b_cnt !== 2'd0) begin errors++; $display("FAIL coll_clr_cnt got=%0d/%0d exp=0/0", a_cnt, b_cnt); end
    if (b_match !== 1'b0 || a_prog !== 4'b0) begin errors++; $display("FAIL coll_clr_state got=%b/%b exp=0/0000", b_match, a_prog); end
  endtask

  task automatic test_saturation();
    int pulses;
    pulses = 0;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      send_default();
      if (b_match === 1'b1) pulses++;
    end
    idle();
    checks += 3;
    if (pulses != 5) begin errors++; $display("FAIL sat_pulses got=%0d exp=5", pulses); end
    if (b_cnt !== 2'd3) begin errors++; $display("FAIL sat_b_cnt got=%0d exp=3", b_cnt); end
    if (a_cnt !== 8'd5) begin errors++; $display("FAIL sat_a_cnt got=%0d exp=5", a_cnt); end
  endtask

  task automatic test_random();
    logic c, v, we;
    logic [1:0] s;
    for (int i = 0; i < 1500; i++) begin
      c  = ($urandom_range(0, 49) == 0);
      we = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 9) < 7) ? pat_m[$urandom_range(0, 3)] : 2'($urandom_range(0, 3));
      drive(c, v, s, we, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)));
    end
    idle();
  endtask

  initial begin
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
    test_reset();
    test_reset_mid();
    test_default();
    test_overlap();
    test_stall();
    test_collisions();
    test_saturation();
    test_random();
    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
